// File: rtl/coef_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coef_pkg
// Description : Shared constants for the FIR coefficient fetch sequencer:
//               default geometry, FIFO depth and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package coef_pkg;

    localparam int DEF_WIDTH_COEF0 = 8;
    localparam int DEF_N_TAPS      = 16;

    localparam int ADDR_W          = $clog2(DEF_N_TAPS / 2);
    localparam int IDX_W           = $clog2(DEF_N_TAPS);

    localparam int FIFO_DEPTH      = 4;
    localparam int FIFO_CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/coef_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : coef_skid_fifo
// Description : Small synchronous FIFO holding {idx, last, coef} entries
//               between the ROM read stage and the MAC handshake. Exposes
//               its fill count so the issuer can budget outstanding reads.
// Revision    : 1.0 - initial release
// ============================================================================
module coef_skid_fifo
    import coef_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_pop,
    output logic [DATA_W-1:0]     o_head,
    output logic [FIFO_CNT_W-1:0] o_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A push into a full FIFO is only accepted when the head leaves at the same edge.
    assign w_push = i_push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, pointers and fill count; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + FIFO_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - FIFO_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coef_fetch.sv
`default_nettype none
// ============================================================================
// Module      : coef_fetch
// Description : Read-side sequencer for the FIR coefficient ROM. Issues ROM
//               addresses, absorbs the one-cycle ROM latency and streams the
//               coefficients to the MAC over valid/ready.
//               Build option COEF_MIRROR_EN: symmetric sweep of N_TAPS
//               coefficients (ROM forwards, then backwards).
// Revision    : 1.0 - initial release
// ============================================================================
module coef_fetch
    import coef_pkg::*;
#(
    parameter int WIDTH_COEF0 = DEF_WIDTH_COEF0,
    parameter int N_TAPS      = DEF_N_TAPS
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          start,
    output logic [$clog2(N_TAPS/2)-1:0]   rom_add,
    input  logic [WIDTH_COEF0-1:0]        rom_q,
    output logic [WIDTH_COEF0-1:0]        coef,
    output logic                          coef_valid,
    input  logic                          coef_ready,
    output logic [$clog2(N_TAPS)-1:0]     coef_idx,
    output logic                          coef_last,
    output logic                          busy,
    output logic                          done
);

    localparam int c_ADDR_W = $clog2(N_TAPS / 2);
    localparam int c_IDX_W  = $clog2(N_TAPS);
`ifdef COEF_MIRROR_EN
    localparam int c_SWEEP_LEN = N_TAPS;
`else
    localparam int c_SWEEP_LEN = N_TAPS / 2;
`endif
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_SWEEP_LEN - 1);
    localparam int c_FIFO_W = c_IDX_W + 1 + WIDTH_COEF0;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_IDX_W-1:0]    r_issue_cnt;
    logic [c_IDX_W-1:0]    r_idx_a;
    logic [c_IDX_W-1:0]    r_idx_b;
    logic                  r_va;
    logic                  r_vb;
    logic [FIFO_CNT_W-1:0] w_fifo_count;
    logic [FIFO_CNT_W-1:0] w_outstanding;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_handshake;
    logic [c_ADDR_W-1:0]   w_addr;
    logic [c_FIFO_W-1:0]   w_push_data;
    logic [c_FIFO_W-1:0]   w_head;

    // Every issued read owns a FIFO slot until popped, so the FIFO can never overflow.
    assign w_outstanding = w_fifo_count + FIFO_CNT_W'(r_va) + FIFO_CNT_W'(r_vb);
    assign w_credit      = (w_outstanding < FIFO_CNT_W'(FIFO_DEPTH));
    assign w_last_issue  = (r_issue_cnt == c_LAST_IDX);

    // Taps in the upper half read the ROM backwards: N-1-k equals the inverted low bits of k.
    assign w_addr = r_issue_cnt[c_IDX_W-1] ? ~r_issue_cnt[c_ADDR_W-1:0]
                                           :  r_issue_cnt[c_ADDR_W-1:0];

    assign w_handshake = coef_valid && coef_ready;
    assign done        = w_handshake && coef_last;
    assign busy        = (r_state != c_ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and issue decision; the first address is issued on the start edge itself.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start && w_credit) begin
                    w_issue      = 1'b1;
                    w_next_state = w_last_issue ? c_ST_DRAIN : c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_last_issue) begin
                        w_next_state = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (done) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Issue counter, ROM address (stage A) and the in-flight ROM read (stage B).
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rom_add     <= '0;
            r_issue_cnt <= '0;
            r_idx_a     <= '0;
            r_idx_b     <= '0;
            r_va        <= 1'b0;
            r_vb        <= 1'b0;
        end else begin
            r_va    <= w_issue;
            r_vb    <= r_va;
            r_idx_b <= r_idx_a;
            if (w_issue) begin
                rom_add     <= w_addr;
                r_idx_a     <= r_issue_cnt;
                r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + c_IDX_W'(1);
            end
        end
    end

    assign w_push_data = {r_idx_b, (r_idx_b == c_LAST_IDX), rom_q};

    coef_skid_fifo #(
        .DATA_W (c_FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (r_vb),
        .i_data  (w_push_data),
        .i_pop   (w_handshake),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    assign coef_idx   = w_head[c_FIFO_W-1 -: c_IDX_W];
    assign coef_last  = w_head[WIDTH_COEF0];
    assign coef       = w_head[WIDTH_COEF0-1:0];
    assign coef_valid = (w_fifo_count != '0);

endmodule
`default_nettype wire
